// File: rtl/texture_quad_fetch.sv
// -----------------------------------------------------------------------------
// texture_quad_fetch
//
// Front end of the bilinear texture filter. It accepts one signed Q16.16
// normalized coordinate pair (S,T) per sample and works out the 2x2 texel
// footprint under repeat or clamp-to-edge wrapping. It then reads the four
// texels one after another from a single-port texture RAM with a fixed read
// latency. Finally it presents the quad and the 16-bit sub-texel fractions
// on a valid/ready output.
//
// Ports
//   aclk, resetn                 clock, synchronous active-low reset
//   confWidthLog2/HeightLog2     log2 of texture width/height (stable unless idle)
//   confClampS/T                 1: clamp-to-edge, 0: repeat, per axis
//   s_valid/s_ready              input handshake
//   s_user                       sideband, returned unchanged on m_user
//   s_texelS/s_texelT            signed Q16.16 coordinates, 1.0 = full texture
//   m_valid/m_ready              output handshake
//   m_user                       sideband of the sample being presented
//   m_texel00/01/10/11           texels at (x0,y0),(x1,y0),(x0,y1),(x1,y1)
//   m_texelSubCoordS/T           fractional position inside the quad
//   texAddr/texRead              texture RAM request (one read per cycle)
//   texData                      RAM data, valid READ_LATENCY cycles after a read
//
// Schedule for an accepted sample (cycle c0 = acceptance):
//   c1..c4        reads of a00, a01, a10, a11
//   c(1+L)..c(4+L) matching data captured (L = READ_LATENCY)
//   c(5+L)        m_valid high, held until m_ready
// Because the RAM latency is fixed, a cycle counter is enough to decide
// which texel register each returning word belongs to. No read tags are needed.
// -----------------------------------------------------------------------------
module texture_quad_fetch #(
  parameter int USER_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic [3:0]            confWidthLog2,
  input  logic [3:0]            confHeightLog2,
  input  logic                  confClampS,
  input  logic                  confClampT,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [USER_WIDTH-1:0] s_user,
  input  logic [31:0]           s_texelS,
  input  logic [31:0]           s_texelT,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [USER_WIDTH-1:0] m_user,
  output logic [31:0]           m_texel00,
  output logic [31:0]           m_texel01,
  output logic [31:0]           m_texel10,
  output logic [31:0]           m_texel11,
  output logic [15:0]           m_texelSubCoordS,
  output logic [15:0]           m_texelSubCoordT,
  output logic [ADDR_WIDTH-1:0] texAddr,
  output logic                  texRead,
  input  logic [31:0]           texData
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // The counter runs from 0 in c1. The last texel word is present when it
  // equals 3 + READ_LATENCY. Its maximum value is 6, so 3 bits are enough.
  localparam logic [2:0] LAST_CAPTURE = 3'(3 + READ_LATENCY);

  state_t                  state_reg;
  logic [2:0]              fetch_cnt_reg;
  logic                    tex_read_reg;
  logic [ADDR_WIDTH-1:0]   tex_addr_reg;
  logic                    m_valid_reg;
  logic [USER_WIDTH-1:0]   m_user_reg;
  logic [15:0]             frac_s_reg;
  logic [15:0]             frac_t_reg;
  logic [ADDR_WIDTH-1:0]   quad_addr_reg  [4];
  logic [ADDR_WIDTH-1:0]   quad_addr_next [4];

  // ---------------------------------------------------------------------------
  // Per-axis coordinate mapping. gi = 0 is S (width), gi = 1 is T (height).
  // The coordinate is scaled by the texture size through a left shift. After
  // that, bits [39:16] are the signed integer texel index and bits [15:0]
  // are the fraction.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [31:0]        coord;
    logic [3:0]         size_log2;
    logic               clamp_en;
    logic signed [39:0] scaled;
    logic signed [23:0] int_part;
    logic signed [23:0] int_inc;
    logic [23:0]        mask;
    logic [23:0]        lo;
    logic [23:0]        hi;
    logic [15:0]        frac;

    assign coord     = (gi == 0) ? s_texelS      : s_texelT;
    assign size_log2 = (gi == 0) ? confWidthLog2 : confHeightLog2;
    assign clamp_en  = (gi == 0) ? confClampS    : confClampT;

    always_comb begin
      scaled   = $signed({{8{coord[31]}}, coord}) <<< size_log2;
      int_part = scaled[39:16];
      int_inc  = int_part + 24'sd1;
      mask     = (24'd1 << size_log2) - 24'd1;
      lo       = int_part & mask;
      hi       = int_inc & mask;
      frac     = scaled[15:0];
      if (clamp_en) begin
        if (int_part < 24'sd0) begin
          // Left of the texture: both taps on the first texel, with no blend.
          lo   = '0;
          hi   = '0;
          frac = '0;
        end else if (int_part >= $signed(mask)) begin
          // On or past the last texel: both taps on the edge texel, no blend.
          lo   = mask;
          hi   = mask;
          frac = '0;
        end else begin
          lo   = int_part;
          hi   = int_inc;
        end
      end
    end
  end

  // Row-major address. Both indices are already inside the texture, so an OR
  // is enough to combine them. The result is truncated to the RAM width.
  function automatic logic [ADDR_WIDTH-1:0] texel_addr(
    input logic [23:0] x,
    input logic [23:0] y,
    input logic [3:0]  width_log2
  );
    return (ADDR_WIDTH'(y) << width_log2) | ADDR_WIDTH'(x);
  endfunction

  assign quad_addr_next[0] = texel_addr(g_axis[0].lo, g_axis[1].lo, confWidthLog2);
  assign quad_addr_next[1] = texel_addr(g_axis[0].hi, g_axis[1].lo, confWidthLog2);
  assign quad_addr_next[2] = texel_addr(g_axis[0].lo, g_axis[1].hi, confWidthLog2);
  assign quad_addr_next[3] = texel_addr(g_axis[0].hi, g_axis[1].hi, confWidthLog2);

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> FETCH -> OUT -> IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      fetch_cnt_reg <= '0;
      tex_read_reg  <= 1'b0;
      tex_addr_reg  <= '0;
      m_valid_reg   <= 1'b0;
      m_user_reg    <= '0;
      frac_s_reg    <= '0;
      frac_t_reg    <= '0;
      for (int k = 0; k < 4; k++) begin
        quad_addr_reg[k] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s_valid) begin
            state_reg     <= ST_FETCH;
            fetch_cnt_reg <= '0;
            // The first read goes out in the cycle right after acceptance.
            tex_read_reg  <= 1'b1;
            tex_addr_reg  <= quad_addr_next[0];
            m_user_reg    <= s_user;
            frac_s_reg    <= g_axis[0].frac;
            frac_t_reg    <= g_axis[1].frac;
            for (int k = 0; k < 4; k++) begin
              quad_addr_reg[k] <= quad_addr_next[k];
            end
          end
        end

        ST_FETCH: begin
          fetch_cnt_reg <= fetch_cnt_reg + 3'd1;
          if (fetch_cnt_reg < 3'd3) begin
            tex_addr_reg <= quad_addr_reg[fetch_cnt_reg[1:0] + 2'd1];
          end else begin
            tex_read_reg <= 1'b0;
          end
          if (fetch_cnt_reg == LAST_CAPTURE) begin
            state_reg   <= ST_OUT;
            m_valid_reg <= 1'b1;
          end
        end

        ST_OUT: begin
          if (m_ready) begin
            state_reg   <= ST_IDLE;
            m_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg    <= ST_IDLE;
          tex_read_reg <= 1'b0;
          m_valid_reg  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Texel capture. Word k of the quad arrives exactly READ_LATENCY cycles
  // after its read. Capture happens only while in FETCH. Any data still in
  // flight from a read that was cut off by reset therefore never lands in
  // these registers.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_texel
    localparam logic [2:0] CAPTURE_AT = 3'(gi + READ_LATENCY);
    logic [31:0] texel_reg;

    always_ff @(posedge aclk) begin
      if (!resetn) begin
        texel_reg <= '0;
      end else if (state_reg == ST_FETCH && fetch_cnt_reg == CAPTURE_AT) begin
        texel_reg <= texData;
      end
    end
  end

  // s_ready looks only at reset and state; m_ready has no path to it.
  assign s_ready          = resetn && (state_reg == ST_IDLE);
  assign m_valid          = m_valid_reg;
  assign m_user           = m_user_reg;
  assign m_texel00        = g_texel[0].texel_reg;
  assign m_texel01        = g_texel[1].texel_reg;
  assign m_texel10        = g_texel[2].texel_reg;
  assign m_texel11        = g_texel[3].texel_reg;
  assign m_texelSubCoordS = frac_s_reg;
  assign m_texelSubCoordT = frac_t_reg;
  assign texAddr          = tex_addr_reg;
  assign texRead          = tex_read_reg;

endmodule

// File: tb/tb_texture_quad_fetch.sv
`timescale 1ns/1ps
// Directed bench for texture_quad_fetch.
// Two instances are used: one with READ_LATENCY=1 and one with READ_LATENCY=3.
// Each has its own fixed-latency RAM model, mem[a] = 0xA000_0000 | a.
// Stimulus goes to the instance chosen by dut_sel, and the checks read
// through a view mux.
module tb_texture_quad_fetch;

  logic        clk;
  logic        resetn;
  logic [3:0]  cfg_w_log2;
  logic [3:0]  cfg_h_log2;
  logic        cfg_clamp_s;
  logic        cfg_clamp_t;
  logic        s_valid;
  logic [0:0]  s_user;
  logic [31:0] s_texel_s;
  logic [31:0] s_texel_t;
  logic        m_ready;
  logic        dut_sel;

  logic        d1_s_ready, d1_m_valid, d1_tex_read;
  logic [0:0]  d1_m_user;
  logic [31:0] d1_t00, d1_t01, d1_t10, d1_t11, d1_tex_data;
  logic [15:0] d1_fs, d1_ft, d1_tex_addr;

  logic        d3_s_ready, d3_m_valid, d3_tex_read;
  logic [0:0]  d3_m_user;
  logic [31:0] d3_t00, d3_t01, d3_t10, d3_t11, d3_tex_data;
  logic [15:0] d3_fs, d3_ft, d3_tex_addr;
  logic [31:0] d3_pipe [3];

  logic        v_s_ready, v_m_valid, v_tex_read;
  logic [0:0]  v_m_user;
  logic [31:0] v_texel [4];
  logic [15:0] v_fs, v_ft, v_tex_addr;

  int assert_count = 0;
  int fail_count   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  texture_quad_fetch #(.USER_WIDTH(1), .ADDR_WIDTH(16), .READ_LATENCY(1)) u_dut1 (
    .aclk(clk), .resetn(resetn),
    .confWidthLog2(cfg_w_log2), .confHeightLog2(cfg_h_log2),
    .confClampS(cfg_clamp_s), .confClampT(cfg_clamp_t),
    .s_valid(s_valid && !dut_sel), .s_ready(d1_s_ready), .s_user(s_user),
    .s_texelS(s_texel_s), .s_texelT(s_texel_t),
    .m_valid(d1_m_valid), .m_ready(m_ready), .m_user(d1_m_user),
    .m_texel00(d1_t00), .m_texel01(d1_t01), .m_texel10(d1_t10), .m_texel11(d1_t11),
    .m_texelSubCoordS(d1_fs), .m_texelSubCoordT(d1_ft),
    .texAddr(d1_tex_addr), .texRead(d1_tex_read), .texData(d1_tex_data)
  );

  texture_quad_fetch #(.USER_WIDTH(1), .ADDR_WIDTH(16), .READ_LATENCY(3)) u_dut3 (
    .aclk(clk), .resetn(resetn),
    .confWidthLog2(cfg_w_log2), .confHeightLog2(cfg_h_log2),
    .confClampS(cfg_clamp_s), .confClampT(cfg_clamp_t),
    .s_valid(s_valid && dut_sel), .s_ready(d3_s_ready), .s_user(s_user),
    .s_texelS(s_texel_s), .s_texelT(s_texel_t),
    .m_valid(d3_m_valid), .m_ready(m_ready), .m_user(d3_m_user),
    .m_texel00(d3_t00), .m_texel01(d3_t01), .m_texel10(d3_t10), .m_texel11(d3_t11),
    .m_texelSubCoordS(d3_fs), .m_texelSubCoordT(d3_ft),
    .texAddr(d3_tex_addr), .texRead(d3_tex_read), .texData(d3_tex_data)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'hA000_0000 | {16'h0000, a};
  endfunction

  // Fixed-latency RAM models. When no read is issued they return a poison word.
  always @(posedge clk) begin
    d1_tex_data <= d1_tex_read ? mem_word(d1_tex_addr) : 32'hDEAD_BEEF;
    d3_pipe[0]  <= d3_tex_read ? mem_word(d3_tex_addr) : 32'hDEAD_BEEF;
    d3_pipe[1]  <= d3_pipe[0];
    d3_pipe[2]  <= d3_pipe[1];
  end
  assign d3_tex_data = d3_pipe[2];

  always_comb begin
    if (dut_sel) begin
      v_s_ready = d3_s_ready;  v_m_valid = d3_m_valid; v_tex_read = d3_tex_read;
      v_m_user  = d3_m_user;   v_fs = d3_fs;  v_ft = d3_ft; v_tex_addr = d3_tex_addr;
      v_texel[0] = d3_t00; v_texel[1] = d3_t01; v_texel[2] = d3_t10; v_texel[3] = d3_t11;
    end else begin
      v_s_ready = d1_s_ready;  v_m_valid = d1_m_valid; v_tex_read = d1_tex_read;
      v_m_user  = d1_m_user;   v_fs = d1_fs;  v_ft = d1_ft; v_tex_addr = d1_tex_addr;
      v_texel[0] = d1_t00; v_texel[1] = d1_t01; v_texel[2] = d1_t10; v_texel[3] = d1_t11;
    end
  end

  task automatic check_value(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sample through the selected instance and checks the whole
  // timeline against hand-computed addresses and fractions.
  task automatic run_sample(input string tag,
                            input logic [3:0] wl, input logic [3:0] hl,
                            input logic cs, input logic ct,
                            input logic [31:0] s, input logic [31:0] t,
                            input logic [0:0] user,
                            input logic [15:0] a0, input logic [15:0] a1,
                            input logic [15:0] a2, input logic [15:0] a3,
                            input logic [15:0] fs, input logic [15:0] ft,
                            input int stall);
    logic [15:0] exp_addr [4];
    int lat;
    int guard;
    exp_addr[0] = a0; exp_addr[1] = a1; exp_addr[2] = a2; exp_addr[3] = a3;
    lat = dut_sel ? 3 : 1;
    cfg_w_log2 = wl; cfg_h_log2 = hl; cfg_clamp_s = cs; cfg_clamp_t = ct;
    s_texel_s = s; s_texel_t = t; s_user = user;
    m_ready = (stall == 0);
    guard = 0;
    while (!v_s_ready && guard < 50) begin
      step();
      guard++;
    end
    check_value({tag, "/ready_c0"}, v_s_ready, 1);
    s_valid = 1'b1;
    step();                                  // c1
    s_valid = 1'b0;
    check_value({tag, "/sready_c1"}, v_s_ready, 0);
    for (int k = 0; k < 4; k++) begin        // c1..c4
      check_value({tag, "/texread"}, v_tex_read, 1);
      check_value({tag, "/texaddr"}, v_tex_addr, exp_addr[k]);
      step();
    end
    for (int c = 0; c < lat; c++) begin      // c5..c(4+lat)
      check_value({tag, "/mvalid_early"}, v_m_valid, 0);
      check_value({tag, "/texread_off"}, v_tex_read, 0);
      step();
    end
    check_value({tag, "/mvalid"}, v_m_valid, 1);
    for (int i = 0; i <= stall; i++) begin
      for (int k = 0; k < 4; k++) begin
        check_value({tag, "/texel"}, v_texel[k], mem_word(exp_addr[k]));
      end
      check_value({tag, "/frac_s"}, v_fs, fs);
      check_value({tag, "/frac_t"}, v_ft, ft);
      check_value({tag, "/user"}, v_m_user, user);
      if (stall != 0) begin
        check_value({tag, "/hold_mvalid"}, v_m_valid, 1);
        check_value({tag, "/hold_texread"}, v_tex_read, 0);
        check_value({tag, "/hold_sready"}, v_s_ready, 0);
      end
      if (i < stall) step();
    end
    m_ready = 1'b1;
    step();                                  // after the handshake
    check_value({tag, "/mvalid_done"}, v_m_valid, 0);
    check_value({tag, "/sready_done"}, v_s_ready, 1);
    $display("sample %s: S=%h T=%h addr %0d,%0d,%0d,%0d fS=%h fT=%h user=%0d",
             tag, s, t, a0, a1, a2, a3, fs, ft, user);
  endtask

  initial begin
    resetn = 1'b0; dut_sel = 1'b0; s_valid = 1'b0; s_user = '0;
    s_texel_s = '0; s_texel_t = '0; m_ready = 1'b1;
    cfg_w_log2 = 4'd2; cfg_h_log2 = 4'd2; cfg_clamp_s = 1'b0; cfg_clamp_t = 1'b0;
    repeat (3) step();

    // Reset state for both instances
    check_value("rst/d1_sready", d1_s_ready, 0);
    check_value("rst/d1_mvalid", d1_m_valid, 0);
    check_value("rst/d1_texread", d1_tex_read, 0);
    check_value("rst/d1_texaddr", d1_tex_addr, 0);
    check_value("rst/d1_texel00", d1_t00, 0);
    check_value("rst/d1_frac_s", d1_fs, 0);
    check_value("rst/d3_sready", d3_s_ready, 0);
    check_value("rst/d3_mvalid", d3_m_valid, 0);
    resetn = 1'b1;
    step();
    check_value("rst/d1_sready_after", d1_s_ready, 1);
    check_value("rst/d3_sready_after", d3_s_ready, 1);

    // READ_LATENCY=1 instance
    dut_sel = 1'b0;
    run_sample("basic",      4'd2, 4'd2, 0, 0, 32'h0000_A000, 32'h0000_4000, 1'b1,
               16'd6, 16'd7, 16'd10, 16'd11, 16'h8000, 16'h0000, 0);
    run_sample("wrap_s",     4'd2, 4'd2, 0, 0, 32'h0000_E000, 32'h0000_0000, 1'b0,
               16'd3, 16'd0, 16'd7, 16'd4, 16'h8000, 16'h0000, 0);
    run_sample("clamp_neg",  4'd2, 4'd2, 1, 0, 32'hFFFF_C000, 32'h0000_0000, 1'b1,
               16'd0, 16'd0, 16'd4, 16'd4, 16'h0000, 16'h0000, 0);
    run_sample("clamp_high", 4'd2, 4'd2, 1, 0, 32'h0000_F000, 32'h0000_0000, 1'b0,
               16'd3, 16'd3, 16'd7, 16'd7, 16'h0000, 16'h0000, 0);
    run_sample("rep_neg",    4'd2, 4'd2, 0, 0, 32'hFFFF_C000, 32'h0000_0000, 1'b1,
               16'd3, 16'd0, 16'd7, 16'd4, 16'h0000, 16'h0000, 0);
    run_sample("rep_high",   4'd2, 4'd2, 0, 0, 32'h0000_F000, 32'h0000_0000, 1'b0,
               16'd3, 16'd0, 16'd7, 16'd4, 16'hC000, 16'h0000, 0);
    run_sample("clamp_t",    4'd2, 4'd2, 0, 1, 32'h0000_A000, 32'hFFFF_C000, 1'b1,
               16'd2, 16'd3, 16'd2, 16'd3, 16'h8000, 16'h0000, 0);
    run_sample("w8_h4",      4'd3, 4'd2, 0, 0, 32'h0000_2800, 32'h0000_D000, 1'b0,
               16'd25, 16'd26, 16'd1, 16'd2, 16'h4000, 16'h4000, 0);
    run_sample("backpress",  4'd2, 4'd2, 0, 0, 32'h0000_A000, 32'h0000_4000, 1'b1,
               16'd6, 16'd7, 16'd10, 16'd11, 16'h8000, 16'h0000, 10);

    // READ_LATENCY=3 instance
    dut_sel = 1'b1;
    #1;
    run_sample("lat3",       4'd2, 4'd2, 0, 0, 32'h0000_A000, 32'h0000_4000, 1'b0,
               16'd6, 16'd7, 16'd10, 16'd11, 16'h8000, 16'h0000, 0);

    // Reset in the middle of a fetch on the latency-3 instance
    cfg_w_log2 = 4'd2; cfg_h_log2 = 4'd2; cfg_clamp_s = 1'b0; cfg_clamp_t = 1'b0;
    s_texel_s = 32'h0000_A000; s_texel_t = 32'h0000_4000; s_user = 1'b1;
    m_ready = 1'b1;
    check_value("rst_mid/ready_c0", v_s_ready, 1);
    s_valid = 1'b1;
    step();                                  // c1
    s_valid = 1'b0;
    check_value("rst_mid/texread_c1", v_tex_read, 1);
    step();                                  // c2
    resetn = 1'b0;
    #1;
    check_value("rst_mid/sready_in_rst", v_s_ready, 0);
    step();                                  // c3
    check_value("rst_mid/mvalid", v_m_valid, 0);
    check_value("rst_mid/texread", v_tex_read, 0);
    check_value("rst_mid/texaddr", v_tex_addr, 0);
    check_value("rst_mid/texel00", v_texel[0], 0);
    resetn = 1'b1;
    #1;
    // Next sample is accepted at once, so stale read data arrives during its fetch
    run_sample("after_rst",  4'd2, 4'd2, 0, 0, 32'h0000_E000, 32'h0000_0000, 1'b0,
               16'd3, 16'd0, 16'd7, 16'd4, 16'h8000, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
